pe_accum: RTL and testbench
===========================

# pe_accum

Parametrised successor processing element for the convolution array. It multiplies MESH_N channel tiles of MESH_X×MESH_Y activations by one weight per channel and reduces across channels in a fully pipelined adder tree. It then accumulates the reduced tile over a variable number of input-channel passes, with saturation and optional ReLU. It sits between the input/weight buffers and the output write-back, and adds valid/ready flow control and multi-pass accumulation.

## Interface
- IN_BIT, 8, activation width, signed two's complement
- WEIGHT_BIT, 8, weight width, signed
- OUT_BIT, 32, accumulator and output lane width, signed
- MESH_X, 8, tile width
- MESH_Y, 8, tile height
- MESH_N, 64, channels per pass; power of two, ≥2
- PASS_BIT, 8, width of pass counter
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes every register
- in_valid  in  1  input beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_first  in  1  beat opens a new accumulation group
- in_last  in  1  beat closes the group
- acc_init_sel  in  1  on first beat: 0 = start from zero, 1 = start from inter_data
- relu_en  in  1  on last beat: clamp negative lanes to 0
- data_in  in  MESH_N*MESH_X*MESH_Y*IN_BIT  channel-major, lane-minor activations
- weight  in  MESH_N*WEIGHT_BIT  one weight per channel
- inter_data  in  MESH_X*MESH_Y*OUT_BIT  partial sums for init
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accept
- data_out  out  MESH_X*MESH_Y*OUT_BIT  result lanes
- out_passes  out  PASS_BIT  beats in the emitted group, saturating at all-ones

## Operation
- Stage P registers lane products: the signed IN_BIT×WEIGHT_BIT product is PROD = IN_BIT+WEIGHT_BIT bits.
- Tree has L = log2(MESH_N) registered levels. Each level widens by 1 bit, so the sum is PROD+L bits.
- Stage A is the accumulator. A sum is sign-extended to OUT_BIT+1 and added with saturation to [-2^(OUT_BIT-1), 2^(OUT_BIT-1)-1] per lane.
  - On a first beat: acc = sat(init + sum), where init is 0 or inter_data.
  - Otherwise: acc = sat(acc + sum).
- in_first, in_last, acc_init_sel, relu_en and inter_data travel as sidebands with the beat's valid bit. They are applied at stage A.
- Pass counter: reset to 1 on a first beat, otherwise increment with saturation.
- On a last beat, stage O loads acc, with relu applied, and the pass count. It sets out_valid, and the group closes.
- A beat that reaches A with no open group is treated as a first beat with zero init.
- in_first on a beat while a group is open discards the open group and restarts.
- A beat with both in_first and in_last is a one-pass group.
- Stall: in_ready = ena && !(out_valid && !out_ready). When in_ready is low, or ena is low, the whole pipeline holds and no valid bit advances.

## Timing
- Latency from accepting a last beat to out_valid is L+3 cycles when there are no stalls. With the default, L=6, so latency is 9 cycles.
- Throughput is one beat per cycle.
- out_valid falls the cycle after out_valid && out_ready, unless a new result loads in that same cycle. A load on the handshake cycle is allowed: back-to-back results.
- data_out and out_passes are stable while out_valid && !out_ready.
- Reset values: out_valid 0, data_out 0, out_passes 0, all pipeline valid bits 0, acc 0, group-open flag 0. in_ready is 1 once ena is high.
- Reset mid-group discards all in-flight beats and the open accumulation. No output is produced for that group.

## Structure
- Package pe_accum_pkg:
  - clog2 function.
  - Lane-width localparams PROD and SUM.
  - Saturating signed-add function.
- Sub-module pe_adder_tree: pipelined MESH_N-input reduction for all lanes, with a valid/sideband shift register and a hold input.
- Top level contains the multiplier stage, the accumulator, and the output register with handshake.

## Test plan
Bench configuration: MESH_N=4, MESH_X=MESH_Y=2, OUT_BIT=16, so L=2 and latency is 5.
1. One-pass group, all data 1, weights 2, init zero → out_valid 5 cycles after the beat; every lane 8; out_passes 1.
2. Three passes, data 3, weight -2, acc_init_sel=1 with inter_data=100 → lanes 28 (100 - 3×24); out_passes 3.
3. Data -128, weight 127, two passes → lanes saturate to -32768 and stay clamped. Repeat with data 127, weight 127 → 32767.
4. Result -24 with relu_en=1 → lanes 0. Same group with relu_en=0 → -24.
5. Hold out_ready low for 5 cycles while a second group streams in → in_ready low and data_out stable throughout. After release, both results arrive in order with nothing lost or duplicated.
6. Assert rst_n low during pass 2 of 3 → all outputs 0 immediately. A subsequent one-pass group returns a clean result (test 1 values).

Source files
------------

// File: rtl/pe_accum_pkg.sv
// -----------------------------------------------------------------------------
// pe_accum_pkg
// Shared helpers for the pe_accum processing element:
//   clog2      - constant ceil(log2) used to size the adder tree
//   PROD, SUM  - lane widths for the default configuration (8x8 over 64 channels)
//   SB_*       - bit positions of the per-beat control flags in the sideband word
//   sat_add    - signed add clamped to an OUT_BIT-wide two's complement range
// -----------------------------------------------------------------------------
package pe_accum_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int DEF_IN_BIT     = 8;
    localparam int DEF_WEIGHT_BIT = 8;
    localparam int DEF_MESH_N     = 64;
    localparam int PROD           = DEF_IN_BIT + DEF_WEIGHT_BIT;
    localparam int SUM            = PROD + clog2(DEF_MESH_N);

    // Sideband word = {inter_data, first, last, acc_init_sel, relu_en}
    localparam int SB_RELU  = 0;
    localparam int SB_INIT  = 1;
    localparam int SB_LAST  = 2;
    localparam int SB_FIRST = 3;
    localparam int SB_FLAGS = 4;

    // Operands arrive sign-extended to 64 bits; one extra bit of headroom makes
    // the raw sum exact before it is clamped (valid for out_bit <= 63).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int              out_bit);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (out_bit - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (out_bit - 1));
        if (s > hi)      s = hi;
        else if (s < lo) s = lo;
        return s[63:0];
    endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// -----------------------------------------------------------------------------
// pe_adder_tree
// Pipelined MESH_N-input reduction, one tree per lane, one register per level.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   hold_i          freeze every register (pipeline stall)
//   valid_i, sb_i   beat valid and sideband, delayed alongside the sums
//   prod_i          MESH_N*LANES products, channel-major, lane-minor
//   valid_o, sb_o   delayed valid / sideband
//   sum_o           LANES reduced sums, SUM_W bits each
// -----------------------------------------------------------------------------
module pe_adder_tree
    import pe_accum_pkg::*;
#(
    parameter int PROD_W = 16,
    parameter int MESH_N = 64,
    parameter int LANES  = 64,
    parameter int SUM_W  = 22,
    parameter int SB_W   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           hold_i,
    input  logic                           valid_i,
    input  logic [SB_W-1:0]                sb_i,
    input  logic [MESH_N*LANES*PROD_W-1:0] prod_i,
    output logic                           valid_o,
    output logic [SB_W-1:0]                sb_o,
    output logic [LANES*SUM_W-1:0]         sum_o
);
    localparam int L = clog2(MESH_N);

    // Heap layout: node n sums children 2n and 2n+1; indices >= MESH_N are
    // the products of channel (index - MESH_N). Node 1 is the root.
    logic signed [SUM_W-1:0] node_d [LANES][1:MESH_N-1];
    logic signed [SUM_W-1:0] node_q [LANES][1:MESH_N-1];
    logic [L-1:0]            vld_q;
    logic [SB_W-1:0]         sb_q [L];

    genvar gl, gi;
    generate
        for (gl = 0; gl < LANES; gl++) begin : g_lane
            for (gi = 1; gi < MESH_N; gi++) begin : g_node
                // Level counted from the leaves; each level is one bit wider.
                // Nodes are stored sign-extended to SUM_W, so only the low
                // W-1 bits of each child carry information.
                localparam int LVL = L - (clog2(gi + 1) - 1);
                localparam int W   = PROD_W + LVL;
                logic [W-2:0]        a;
                logic [W-2:0]        b;
                logic signed [W-1:0] s;
                if (2 * gi >= MESH_N) begin : g_leaf
                    assign a = prod_i[((2*gi   - MESH_N)*LANES + gl)*PROD_W +: PROD_W];
                    assign b = prod_i[((2*gi+1 - MESH_N)*LANES + gl)*PROD_W +: PROD_W];
                end else begin : g_inner
                    assign a = node_q[gl][2*gi][W-2:0];
                    assign b = node_q[gl][2*gi+1][W-2:0];
                end
                assign s = W'(signed'(a)) + W'(signed'(b));
                assign node_d[gl][gi] = SUM_W'(s);
            end
            assign sum_o[gl*SUM_W +: SUM_W] = node_q[gl][1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < L; i++) sb_q[i] <= '0;
            for (int l = 0; l < LANES; l++)
                for (int n = 1; n < MESH_N; n++) node_q[l][n] <= '0;
        end else if (!hold_i) begin
            vld_q[0] <= valid_i;
            sb_q[0]  <= sb_i;
            for (int i = 1; i < L; i++) begin
                vld_q[i] <= vld_q[i-1];
                sb_q[i]  <= sb_q[i-1];
            end
            node_q <= node_d;
        end
    end

    assign valid_o = vld_q[L-1];
    assign sb_o    = sb_q[L-1];

endmodule

// File: rtl/pe_accum.sv
// -----------------------------------------------------------------------------
// pe_accum
// Multiplies MESH_N channel tiles by one weight per channel, reduces across
// channels, and accumulates the tile over a group of passes with saturation
// and optional ReLU. Pipeline: P (products) -> tree (L levels) -> A (acc) -> O.
// Ports:
//   clk, rst_n, ena                 clock, async active-low reset, global enable
//   in_valid/in_ready               input beat handshake
//   in_first, in_last               group delimiters
//   acc_init_sel, inter_data        first-beat init source (0 = zero)
//   relu_en                         last-beat clamp of negative lanes
//   data_in, weight                 activations (channel-major) and weights
//   out_valid/out_ready             result handshake
//   data_out, out_passes            result lanes and number of beats in group
// -----------------------------------------------------------------------------
module pe_accum
    import pe_accum_pkg::*;
#(
    parameter int IN_BIT     = 8,
    parameter int WEIGHT_BIT = 8,
    parameter int OUT_BIT    = 32,
    parameter int MESH_X     = 8,
    parameter int MESH_Y     = 8,
    parameter int MESH_N     = 64,
    parameter int PASS_BIT   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  ena,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_first,
    input  logic                                  in_last,
    input  logic                                  acc_init_sel,
    input  logic                                  relu_en,
    input  logic [MESH_N*MESH_X*MESH_Y*IN_BIT-1:0] data_in,
    input  logic [MESH_N*WEIGHT_BIT-1:0]          weight,
    input  logic [MESH_X*MESH_Y*OUT_BIT-1:0]      inter_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [MESH_X*MESH_Y*OUT_BIT-1:0]      data_out,
    output logic [PASS_BIT-1:0]                   out_passes
);
    localparam int LANES  = MESH_X * MESH_Y;
    localparam int PROD_W = IN_BIT + WEIGHT_BIT;
    localparam int SUM_W  = PROD_W + clog2(MESH_N);
    localparam int SB_W   = SB_FLAGS + LANES * OUT_BIT;

    // A full, unaccepted output blocks everything upstream; ena gates all state.
    assign in_ready = ena && !(out_valid_q && !out_ready);

    // ---------------- Stage P: lane products ----------------
    logic [MESH_N*LANES*PROD_W-1:0] prod_d;
    logic [MESH_N*LANES*PROD_W-1:0] p_prod_q;
    logic                           p_valid_q;
    logic [SB_W-1:0]                p_sb_q;

    genvar gc, gi;
    generate
        for (gc = 0; gc < MESH_N; gc++) begin : g_ch
            for (gi = 0; gi < LANES; gi++) begin : g_mul
                assign prod_d[(gc*LANES + gi)*PROD_W +: PROD_W] =
                    PROD_W'(signed'(data_in[(gc*LANES + gi)*IN_BIT +: IN_BIT])) *
                    PROD_W'(signed'(weight[gc*WEIGHT_BIT +: WEIGHT_BIT]));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_q <= 1'b0;
            p_sb_q    <= '0;
            p_prod_q  <= '0;
        end else if (in_ready) begin
            p_valid_q <= in_valid;
            p_sb_q    <= {inter_data, in_first, in_last, acc_init_sel, relu_en};
            p_prod_q  <= prod_d;
        end
    end

    // ---------------- Channel reduction ----------------
    logic                   t_valid;
    logic [SB_W-1:0]        t_sb;
    logic [LANES*SUM_W-1:0] t_sum;

    pe_adder_tree #(
        .PROD_W (PROD_W),
        .MESH_N (MESH_N),
        .LANES  (LANES),
        .SUM_W  (SUM_W),
        .SB_W   (SB_W)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (!in_ready),
        .valid_i (p_valid_q),
        .sb_i    (p_sb_q),
        .prod_i  (p_prod_q),
        .valid_o (t_valid),
        .sb_o    (t_sb),
        .sum_o   (t_sum)
    );

    // ---------------- Stage A: accumulator ----------------
    logic [LANES*OUT_BIT-1:0] acc_q, acc_d;
    logic [PASS_BIT-1:0]      pass_q, pass_d;
    logic                     open_q;
    logic                     a_valid_q, a_last_q, a_relu_q;
    logic                     start_new;

    // A beat arriving with no open group starts one from zero even without
    // in_first; inter_data is only honoured on an explicit first beat.
    assign start_new = t_sb[SB_FIRST] || !open_q;

    always_comb begin
        logic signed [63:0] base;
        logic signed [63:0] res;
        acc_d = acc_q;
        for (int l = 0; l < LANES; l++) begin
            if (!start_new)
                base = 64'(signed'(acc_q[l*OUT_BIT +: OUT_BIT]));
            else if (t_sb[SB_FIRST] && t_sb[SB_INIT])
                base = 64'(signed'(t_sb[SB_FLAGS + l*OUT_BIT +: OUT_BIT]));
            else
                base = '0;
            res = sat_add(base, 64'(signed'(t_sum[l*SUM_W +: SUM_W])), OUT_BIT);
            acc_d[l*OUT_BIT +: OUT_BIT] = res[OUT_BIT-1:0];
        end
        if (start_new)   pass_d = PASS_BIT'(1);
        else if (&pass_q) pass_d = pass_q;
        else             pass_d = pass_q + PASS_BIT'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            pass_q    <= '0;
            open_q    <= 1'b0;
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            a_relu_q  <= 1'b0;
        end else if (in_ready) begin
            a_valid_q <= t_valid;
            a_last_q  <= t_sb[SB_LAST];
            a_relu_q  <= t_sb[SB_RELU];
            if (t_valid) begin
                acc_q  <= acc_d;
                pass_q <= pass_d;
                open_q <= !t_sb[SB_LAST];
            end
        end
    end

    // ---------------- Stage O: output register ----------------
    logic [LANES*OUT_BIT-1:0] relu_d, data_q;
    logic [PASS_BIT-1:0]      passes_q;
    logic                     out_valid_q;
    logic                     load;

    // in_ready already implies the slot is empty or being drained this cycle.
    assign load = in_ready && a_valid_q && a_last_q;

    always_comb begin
        relu_d = acc_q;
        for (int l = 0; l < LANES; l++)
            if (a_relu_q && acc_q[l*OUT_BIT + OUT_BIT - 1])
                relu_d[l*OUT_BIT +: OUT_BIT] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            passes_q    <= '0;
        end else if (ena) begin
            if (load) begin
                out_valid_q <= 1'b1;
                data_q      <= relu_d;
                passes_q    <= pass_q;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign data_out   = data_q;
    assign out_passes = passes_q;

endmodule

// File: tb/tb_pe_accum.sv
module tb_pe_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic        in_first;
    logic        in_last;
    logic        acc_init_sel;
    logic        relu_en;
    logic [127:0] data_in;
    logic [31:0]  weight;
    logic [63:0]  inter_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;
    logic [7:0]  out_passes;

    int checks = 0;
    int errors = 0;

    pe_accum #(
        .IN_BIT     (8),
        .WEIGHT_BIT (8),
        .OUT_BIT    (16),
        .MESH_X     (2),
        .MESH_Y     (2),
        .MESH_N     (4),
        .PASS_BIT   (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_first     (in_first),
        .in_last      (in_last),
        .acc_init_sel (acc_init_sel),
        .relu_en      (relu_en),
        .data_in      (data_in),
        .weight       (weight),
        .inter_data   (inter_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .out_passes   (out_passes)
    );

    always #5 clk = ~clk;

    // Present one beat with uniform data/weight/inter values and wait until it is accepted.
    task automatic drive(input bit f, input bit l, input bit s, input bit r,
                         input logic [7:0] d, input logic [7:0] w, input logic [15:0] iv);
        for (int i = 0; i < 16; i++) data_in[i*8 +: 8] = d;
        for (int c = 0; c < 4; c++)  weight[c*8 +: 8] = w;
        for (int j = 0; j < 4; j++)  inter_data[j*16 +: 16] = iv;
        in_first = f; in_last = l; acc_init_sel = s; relu_en = r;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        acc_init_sel = 1'b0; relu_en = 1'b0;
    endtask

    // Wait (bounded) for out_valid; cycles is counted from the cycle the last beat was presented.
    task automatic collect(output bit got, output int cycles,
                           output logic [63:0] d, output logic [7:0] p);
        got = 1'b0; cycles = 0; d = '0; p = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                got = 1'b1; cycles = k + 1; d = data_out; p = out_passes;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_first = 1'b0; in_last = 1'b0; acc_init_sel = 1'b0; relu_en = 1'b0;
        data_in = '0; weight = '0; inter_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", data_out); end
        checks++; if (out_passes !== 8'd0) begin errors++; $display("FAIL reset_passes got %0d want 0", out_passes); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: outputs idle, in_ready=%b", in_ready);
    endtask

    task automatic test_one_pass();
        bit got; int cyc; logic [63:0] d; logic [7:0] p;
        drive(1, 1, 0, 0, 8'd1, 8'd2, 16'd0);
        collect(got, cyc, d, p);
        checks++; if (!got) begin errors++; $display("FAIL one_pass_valid got none want 1"); end
        checks++; if (cyc != 5) begin errors++; $display("FAIL one_pass_latency got %0d want 5", cyc); end
        checks++; if (d !== {4{16'd8}}) begin errors++; $display("FAIL one_pass_data got %h want %h", d, {4{16'd8}}); end
        checks++; if (p !== 8'd1) begin errors++; $display("FAIL one_pass_passes got %0d want 1", p); end
        $display("one_pass: data=%h passes=%0d latency=%0d", d, p, cyc);
    endtask

    task automatic test_multi_pass_init();
        bit got; int cyc; logic [63:0] d; logic [7:0] p;
        // 3 * -2 * 4 channels = -24 per pass; 100 - 72 = 28
        drive(1, 0, 1, 0, 8'd3, 8'hFE, 16'd100);
        drive(0, 0, 0, 0, 8'd3, 8'hFE, 16'd0);
        drive(0, 1, 0, 0, 8'd3, 8'hFE, 16'd0);
        collect(got, cyc, d, p);
        checks++; if (!got) begin errors++; $display("FAIL multi_valid got none want 1"); end
        checks++; if (d !== {4{16'd28}}) begin errors++; $display("FAIL multi_data got %h want %h", d, {4{16'd28}}); end
        checks++; if (p !== 8'd3) begin errors++; $display("FAIL multi_passes got %0d want 3", p); end
        $display("multi_pass_init: data=%h passes=%0d", d, p);
    endtask

    task automatic test_saturation();
        bit got; int cyc; logic [63:0] d; logic [7:0] p;
        // -128*127*4 = -65024 per pass -> clamps at -32768 and stays there
        drive(1, 0, 0, 0, 8'h80, 8'd127, 16'd0);
        drive(0, 1, 0, 0, 8'h80, 8'd127, 16'd0);
        collect(got, cyc, d, p);
        checks++; if (!got) begin errors++; $display("FAIL sat_neg_valid got none want 1"); end
        checks++; if (d !== {4{16'h8000}}) begin errors++; $display("FAIL sat_neg_data got %h want %h", d, {4{16'h8000}}); end
        checks++; if (p !== 8'd2) begin errors++; $display("FAIL sat_neg_passes got %0d want 2", p); end
        $display("saturation_neg: data=%h passes=%0d", d, p);
        // 127*127*4 = 64516 per pass -> clamps at 32767
        drive(1, 0, 0, 0, 8'd127, 8'd127, 16'd0);
        drive(0, 1, 0, 0, 8'd127, 8'd127, 16'd0);
        collect(got, cyc, d, p);
        checks++; if (!got) begin errors++; $display("FAIL sat_pos_valid got none want 1"); end
        checks++; if (d !== {4{16'h7FFF}}) begin errors++; $display("FAIL sat_pos_data got %h want %h", d, {4{16'h7FFF}}); end
        checks++; if (p !== 8'd2) begin errors++; $display("FAIL sat_pos_passes got %0d want 2", p); end
        $display("saturation_pos: data=%h passes=%0d", d, p);
    endtask

    task automatic test_relu();
        bit got; int cyc; logic [63:0] d; logic [7:0] p;
        drive(1, 1, 0, 1, 8'd3, 8'hFE, 16'd0);
        collect(got, cyc, d, p);
        checks++; if (!got) begin errors++; $display("FAIL relu_on_valid got none want 1"); end
        checks++; if (d !== 64'd0) begin errors++; $display("FAIL relu_on_data got %h want 0", d); end
        $display("relu_on: data=%h", d);
        drive(1, 1, 0, 0, 8'd3, 8'hFE, 16'd0);
        collect(got, cyc, d, p);
        checks++; if (!got) begin errors++; $display("FAIL relu_off_valid got none want 1"); end
        checks++; if (d !== {4{16'hFFE8}}) begin errors++; $display("FAIL relu_off_data got %h want %h", d, {4{16'hFFE8}}); end
        $display("relu_off: data=%h", d);
    endtask

    task automatic test_back_to_back();
        bit got; int cyc; int extra; bit seen; logic [63:0] d; logic [7:0] p;
        // Group A: one pass -> 8. Group B: -24 then +8 -> -16, 2 passes.
        drive(1, 1, 0, 0, 8'd1, 8'd2, 16'd0);
        out_ready = 1'b0;
        drive(1, 0, 0, 0, 8'd3, 8'hFE, 16'd0);
        drive(0, 1, 0, 0, 8'd1, 8'd2, 16'd0);
        seen = out_valid;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        checks++; if (!seen) begin errors++; $display("FAIL stall_first_valid got none want 1"); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc %0d got %b want 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b want 1", k, out_valid); end
            checks++; if (data_out !== {4{16'd8}}) begin errors++; $display("FAIL stall_data cyc %0d got %h want %h", k, data_out, {4{16'd8}}); end
        end
        checks++; if (out_passes !== 8'd1) begin errors++; $display("FAIL stall_passes got %0d want 1", out_passes); end
        $display("stall: held data=%h passes=%0d for 5 cycles", data_out, out_passes);
        out_ready = 1'b1;
        collect(got, cyc, d, p);
        checks++; if (!got) begin errors++; $display("FAIL b2b_second_valid got none want 1"); end
        checks++; if (d !== {4{16'hFFF0}}) begin errors++; $display("FAIL b2b_second_data got %h want %h", d, {4{16'hFFF0}}); end
        checks++; if (p !== 8'd2) begin errors++; $display("FAIL b2b_second_passes got %0d want 2", p); end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL b2b_duplicate got %0d extra results want 0", extra); end
        $display("back_to_back: second data=%h passes=%0d extra=%0d", d, p, extra);
    endtask

    task automatic test_reset_mid_group();
        bit got; int cyc; int extra; logic [63:0] d; logic [7:0] p;
        drive(1, 0, 0, 0, 8'd3, 8'hFE, 16'd0);
        drive(0, 0, 0, 0, 8'd3, 8'hFE, 16'd0);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL midrst_data got %h want 0", data_out); end
        checks++; if (out_passes !== 8'd0) begin errors++; $display("FAIL midrst_passes got %0d want 0", out_passes); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL midrst_ghost got %0d results want 0", extra); end
        drive(1, 1, 0, 0, 8'd1, 8'd2, 16'd0);
        collect(got, cyc, d, p);
        checks++; if (!got) begin errors++; $display("FAIL post_rst_valid got none want 1"); end
        checks++; if (d !== {4{16'd8}}) begin errors++; $display("FAIL post_rst_data got %h want %h", d, {4{16'd8}}); end
        checks++; if (p !== 8'd1) begin errors++; $display("FAIL post_rst_passes got %0d want 1", p); end
        $display("reset_mid_group: post-reset data=%h passes=%0d", d, p);
    endtask

    initial begin
        test_reset();
        test_one_pass();
        test_multi_pass_init();
        test_saturation();
        test_relu();
        test_back_to_back();
        test_reset_mid_group();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
